// File: rtl/sort_readout_if.sv
// sort_readout_if: streaming output bus of the sort readout block.
// Carries one bank element per transfer with a valid/ready handshake.
//   out_data  : element value (WIDTH bits), driven by master
//   out_valid : out_data/out_index are valid, driven by master
//   out_index : bank index of the element on out_data (IW bits), driven by master
//   out_ready : consumer accepts the current element, driven by slave
interface sort_readout_if #(
  parameter int WIDTH = 8,
  parameter int IW    = 3
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [IW-1:0]    out_index;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    output out_index,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_index,
    output out_ready
  );
endinterface

// File: rtl/sort_readout.sv
// sort_readout: captures the sorter's N-element register bank on a load strobe
// and streams the elements out one per valid/ready transfer, in ascending
// (element 0 first) or descending (element N-1 first) order.
// Ports:
//   clk     : system clock, all state changes on posedge
//   reset   : asynchronous active-low reset
//   load    : capture request, honoured only while idle
//   dir     : order select sampled with load (0 = ascending, 1 = descending)
//   in_flat : parallel bank, element k at in_flat[k*WIDTH +: WIDTH]
//   stream  : output bus (out_data, out_valid, out_index, out_ready)
//   busy    : high while streaming and during the done cycle
//   done    : one-cycle pulse after the last element is accepted
module sort_readout #(
  parameter int N     = 8,
  parameter int WIDTH = 8,
  parameter int IW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 dir,
  input  logic [N*WIDTH-1:0]   in_flat,
  sort_readout_if.master       stream,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t           state_r, state_s;
  logic [WIDTH-1:0] buf_r [N];
  logic             dir_r, dir_s;
  logic [IW-1:0]    cnt_r, cnt_s;       // transfers already completed
  logic [WIDTH-1:0] data_r, data_s;
  logic             valid_r, valid_s;
  logic [IW-1:0]    index_r, index_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             capture_s;
  logic [IW-1:0]    step_idx_s;         // index following the one on the bus

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_s    = state_r;
    dir_s      = dir_r;
    cnt_s      = cnt_r;
    data_s     = data_r;
    valid_s    = valid_r;
    index_s    = index_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    capture_s  = 1'b0;
    if (dir_r) begin
      step_idx_s = index_r - IW'(1);
    end else begin
      step_idx_s = index_r + IW'(1);
    end
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (load) begin
          // First element comes straight from the bus so it is valid one
          // cycle after the load sample, without waiting for the buffer.
          state_s   = SEND;
          capture_s = 1'b1;
          dir_s     = dir;
          cnt_s     = {IW{1'b0}};
          valid_s   = 1'b1;
          busy_s    = 1'b1;
          if (dir) begin
            index_s = LAST_IDX;
            data_s  = in_flat[(N-1)*WIDTH +: WIDTH];
          end else begin
            index_s = {IW{1'b0}};
            data_s  = in_flat[WIDTH-1:0];
          end
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (valid_r && stream.out_ready) begin
          if (cnt_r == LAST_IDX) begin
            state_s = DONE;
            valid_s = 1'b0;
            done_s  = 1'b1;
          end else begin
            cnt_s   = cnt_r + IW'(1);
            index_s = step_idx_s;
            data_s  = buf_r[step_idx_s];
          end
        end else begin
          state_s = SEND;
        end
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      dir_r   <= 1'b0;
      cnt_r   <= {IW{1'b0}};
      data_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      index_r <= {IW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      dir_r   <= dir_s;
      cnt_r   <= cnt_s;
      data_r  <= data_s;
      valid_r <= valid_s;
      index_r <= index_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Bank snapshot, written only on an accepted load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        buf_r[k] <= {WIDTH{1'b0}};
      end
    end else if (capture_s) begin
      for (int k = 0; k < N; k++) begin
        buf_r[k] <= in_flat[k*WIDTH +: WIDTH];
      end
    end
  end

  assign stream.out_data  = data_r;
  assign stream.out_valid = valid_r;
  assign stream.out_index = index_r;
  assign busy             = busy_r;
  assign done             = done_r;

endmodule

// File: tb/tb_sort_readout.sv
// tb_sort_readout: self-checking bench for sort_readout. A queue-based model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_sort_readout;
  localparam int N  = 8;
  localparam int W  = 8;
  localparam int IW = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           load = 1'b0;
  logic           dir = 1'b0;
  logic [N*W-1:0] in_flat = '0;
  logic           busy;
  logic           done;

  sort_readout_if #(.WIDTH(W), .IW(IW)) bus ();

  sort_readout #(.N(N), .WIDTH(W), .IW(IW)) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .dir    (dir),
    .in_flat(in_flat),
    .stream (bus),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  logic [W-1:0] vals [N] = '{8'h03, 8'h07, 8'h0A, 8'h11, 8'h2C, 8'h40, 8'h9B, 8'hFE};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [IW-1:0] idx;
    logic [W-1:0]  data;
  } elem_t;

  elem_t        m_q[$];           // elements still to be delivered, in order
  logic         m_done = 1'b0;    // done cycle expected now
  logic         m_zero_data = 1'b1;
  logic [W-1:0] got_q[$];         // values actually accepted from the DUT
  logic [IW-1:0] gidx_q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_done      <= 1'b0;
      m_zero_data <= 1'b1;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        gidx_q.push_back(bus.out_index);
      end
      if (m_q.size() > 0) begin
        if (bus.out_ready) begin
          if (m_q.size() == 1) m_done <= 1'b1;
          void'(m_q.pop_front());
        end
      end else if (m_done) begin
        m_done <= 1'b0;
      end else if (load) begin
        m_zero_data <= 1'b0;
        for (int k = 0; k < N; k++) begin
          elem_t e;
          int    i;
          i      = dir ? (N - 1 - k) : k;
          e.idx  = IW'(i);
          e.data = in_flat[i*W +: W];
          m_q.push_back(e);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  int busy_cnt = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    check("valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
    check("busy", 32'(busy), 32'((m_q.size() > 0) || m_done));
    check("done", 32'(done), 32'(m_done));
    if (m_q.size() > 0) begin
      check("data", 32'(bus.out_data), 32'(m_q[0].data));
      check("index", 32'(bus.out_index), 32'(m_q[0].idx));
    end else if (m_zero_data) begin
      check("idle_data", 32'(bus.out_data), 32'h0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bank_vals();
    for (int k = 0; k < N; k++) in_flat[k*W +: W] = vals[k];
  endtask

  task automatic start(input logic d);
    dir  = d;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, 32'(n < budget), 32'h1);
  endtask

  int b0, d0, g0;

  initial begin
    bus.out_ready = 1'b1;

    // Reset held with load high, then released with load low.
    #1;
    reset = 1'b0;
    load  = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_data", 32'(bus.out_data), 32'h0);
    @(negedge clk);
    load  = 1'b0;
    reset = 1'b1;
    repeat (10) tick();
    check("idle_valid", 32'(bus.out_valid), 32'h0);

    // Ascending stream.
    set_bank_vals();
    b0 = busy_cnt; d0 = done_cnt; g0 = got_q.size();
    start(1'b0);
    check("asc_first_valid", 32'(bus.out_valid), 32'h1);
    check("asc_first_data", 32'(bus.out_data), 32'h03);
    check("asc_first_index", 32'(bus.out_index), 32'h0);
    wait_done("asc", 40);
    repeat (2) tick();
    check("asc_busy_cycles", 32'(busy_cnt - b0), 32'd9);
    check("asc_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("asc_count", 32'(got_q.size() - g0), 32'd8);
    for (int k = 0; k < N; k++) begin
      check("asc_value", 32'(got_q[g0+k]), 32'(vals[k]));
      check("asc_idx", 32'(gidx_q[g0+k]), 32'(k));
    end

    // Descending stream.
    d0 = done_cnt; g0 = got_q.size();
    start(1'b1);
    check("desc_first_data", 32'(bus.out_data), 32'hFE);
    check("desc_first_index", 32'(bus.out_index), 32'd7);
    wait_done("desc", 40);
    repeat (2) tick();
    check("desc_done_pulses", 32'(done_cnt - d0), 32'd1);
    for (int k = 0; k < N; k++) begin
      check("desc_value", 32'(got_q[g0+k]), 32'(vals[N-1-k]));
      check("desc_idx", 32'(gidx_q[g0+k]), 32'(N-1-k));
    end

    // Backpressure: ready pattern 1,0,0,1,0,0,...
    d0 = done_cnt; g0 = got_q.size();
    start(1'b0);
    for (int n = 0; n < 60 && !done; n++) begin
      bus.out_ready = (n % 3 == 0);
      tick();
    end
    bus.out_ready = 1'b1;
    check("bp_done_seen", 32'(done), 32'h1);
    repeat (2) tick();
    check("bp_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("bp_count", 32'(got_q.size() - g0), 32'd8);
    for (int k = 0; k < N; k++) check("bp_value", 32'(got_q[g0+k]), 32'(vals[k]));

    // Load and bus change during SEND are ignored; held load restarts after done.
    g0 = got_q.size();
    start(1'b0);
    tick();
    for (int k = 0; k < N; k++) in_flat[k*W +: W] = 8'hAA;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    load = 1'b1;
    wait_done("ld", 40);
    tick();
    check("ld_gap_idle", 32'(bus.out_valid), 32'h0);
    tick();
    check("ld_restart_valid", 32'(bus.out_valid), 32'h1);
    check("ld_restart_data", 32'(bus.out_data), 32'hAA);
    load = 1'b0;
    wait_done("ld2", 40);
    repeat (2) tick();
    check("ld_count", 32'(got_q.size() - g0), 32'd16);
    for (int k = 0; k < N; k++) begin
      check("ld_orig", 32'(got_q[g0+k]), 32'(vals[k]));
      check("ld_fresh", 32'(got_q[g0+N+k]), 32'hAA);
    end

    // Asynchronous reset after the third transfer.
    set_bank_vals();
    g0 = got_q.size();
    start(1'b0);
    for (int n = 0; n < 20 && (got_q.size() - g0) < 3; n++) tick();
    check("rs_three", 32'(got_q.size() - g0), 32'd3);
    d0 = done_cnt;
    #2;
    reset = 1'b0;
    #1;
    check("rs_valid", 32'(bus.out_valid), 32'h0);
    check("rs_busy", 32'(busy), 32'h0);
    check("rs_done", 32'(done), 32'h0);
    check("rs_data", 32'(bus.out_data), 32'h0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    repeat (3) tick();
    check("rs_no_done", 32'(done_cnt - d0), 32'd0);
    start(1'b0);
    check("rs_fresh_index", 32'(bus.out_index), 32'h0);
    check("rs_fresh_data", 32'(bus.out_data), 32'h03);
    wait_done("rs", 40);
    repeat (2) tick();
    check("rs_done_pulses", 32'(done_cnt - d0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sort_readout.md
Name: sort_readout

Overview:
- Drains the Sorter's register bank: captures N sorted WIDTH-bit values in parallel on a load strobe, then streams them out one per transfer over a valid/ready handshake.
- Sits between the sorter core's output registers and the downstream consumer, such as a display driver or UART transmitter.
- Supports ascending order (element 0 first) or descending order (element N-1 first), selected per load.

Parameters:
- N, 8, number of elements in the bank (N >= 2).
- WIDTH, 8, bits per element.
- IW, $clog2(N), width of the element index output.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset. reset=0 clears all state immediately, independent of clk.
- load  input  1  capture request. Sampled only in IDLE.
- dir  input  1  order select, sampled with load. 0 = element 0 first, 1 = element N-1 first.
- in_flat  input  N*WIDTH  parallel bank contents. Element k is in_flat[k*WIDTH +: WIDTH].
- out_data  output  WIDTH  current element; registered.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_index  output  IW  bank index of the element currently on out_data.
- busy  output  1  high in SEND and DONE.
- done  output  1  one-cycle pulse after the last element is accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - State is IDLE.
  - out_data=0, out_valid=0, out_index=0, busy=0, done=0.
  - Internal buffer and transfer counter are cleared.
  - Release is synchronous to the next posedge; the first action after release is the IDLE evaluation.
- State machine: IDLE, SEND, DONE.
- IDLE:
  - On posedge with load=1, all N elements are copied from in_flat into the internal buffer and dir is latched.
  - The block moves to SEND with out_valid=1 at that same edge.
  - First element: out_data=element 0 and out_index=0 if dir=0; out_data=element N-1 and out_index=N-1 if dir=1.
  - Latency is one cycle from the load sample to the first valid.
  - load=0 keeps the block in IDLE.
- SEND:
  - A transfer occurs on a posedge where out_valid=1 and out_ready=1.
  - On a transfer that is not the last, out_index steps +1 (dir=0) or -1 (dir=1), and out_data takes the next buffered element at the same edge. There are no bubbles, so throughput is 1 element/cycle with out_ready held high.
  - out_valid=0 and out_ready=1: no effect (cannot occur in SEND).
  - out_valid=1 and out_ready=0: out_data, out_index and out_valid are held stable.
  - Exactly N transfers per load. The Nth transfer moves to DONE and drives out_valid=0 at that edge.
  - out_index never wraps. The last index is N-1 (dir=0) or 0 (dir=1).
- DONE:
  - done=1 and busy=1 for exactly one cycle, then return to IDLE with done=0 and busy=0.
- load handling:
  - load is ignored in SEND and DONE; in_flat changes there do not affect the buffered data.
  - load held high continuously in IDLE starts a new sequence on the first IDLE cycle after DONE.
  - The gap between the last transfer and the next first-valid is therefore 2 cycles.
- dir and in_flat are don't-care except on the accepted load edge.
- Reset asserted mid-SEND or mid-DONE aborts immediately: outputs go to reset values, and no done pulse is produced.
- out_index width IW. Buffer indexing uses the latched dir only.

Test Plan:
- Reset/idle: hold reset=0 with load=1, then release with load=0 → out_valid=0, busy=0, done=0, out_data=0 for 10 cycles.
- Ascending stream: in_flat elements 0..7 = 0x03,0x07,0x0A,0x11,0x2C,0x40,0x9B,0xFE; dir=0; load 1 cycle; out_ready=1 → out_valid high 8 consecutive cycles starting 1 cycle after load, with out_data 0x03..0xFE in order and out_index 0..7. done pulses exactly once on the cycle after 0xFE is accepted; busy is high for 9 cycles.
- Descending stream: same data with dir=1 → out_data 0xFE,0x9B,...,0x03 and out_index 7..0, then done.
- Backpressure: dir=0, out_ready toggling 1,0,0,1,... → out_data and out_index stable during ready-low cycles. All 8 values are delivered once, in order, with no duplicates; done fires after the 8th acceptance.
- Load during SEND and bus change: mid-stream pulse load=1 with in_flat all 0xAA → ignored, original values are still streamed. A load on the first IDLE cycle after done starts a fresh 0xAA stream.
- Reset mid-operation: drive reset=0 asynchronously (between clock edges) after the 3rd transfer → out_valid, busy and done drop immediately, and no done pulse occurs. A fresh load after release streams from index 0.
